branch_resolve_stage: RTL and testbench

Sequential branch-resolution stage directly downstream of the ALU in the execute path. Captures the ALU `zero` flag with the decoded branch/jump operation, computes the next program counter, and commits it to the architectural PC through a valid/ready handshake. Asserts a one-cycle `flush` on taken control transfers so fetch/decode can discard wrong-path instructions.

---
 rtl/branch_resolve_stage_if.sv | 26 ++
 rtl/branch_resolve_stage.sv | 178 +++++++++++++++++
 tb/tb_branch_resolve_stage.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_stage_if.sv
// Handshake and branch-info bundle between the ALU stage, the branch resolve stage and fetch.
interface branch_resolve_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  br_op;
  logic        alu_zero;
  logic [31:0] br_offset;
  logic [25:0] jmp_target;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        next_valid;
  logic        next_ready;
  logic        taken;
  logic        flush;

  // master: upstream/downstream environment; slave: the resolve stage
  modport master (
    output in_valid, br_op, alu_zero, br_offset, jmp_target, next_ready,
    input  in_ready, pc, next_pc, next_valid, taken, flush
  );

  modport slave (
    input  in_valid, br_op, alu_zero, br_offset, jmp_target, next_ready,
    output in_ready, pc, next_pc, next_valid, taken, flush
  );
endinterface

// File: rtl/branch_resolve_stage.sv
// Branch resolution stage: captures ALU zero + branch op, resolves the next PC and commits it to the PC.
// Optional macro BRANCH_STATS_EN adds saturating taken/resolved commit counters.
module branch_resolve_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_resolve_stage_if.slave bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]           taken_count,
  output logic [15:0]           resolved_count
`endif
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned JTW  = 26;
  localparam int unsigned CNTW = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EVAL   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_SEQ = 2'b00,
    OP_BEQ = 2'b01,
    OP_BNE = 2'b10,
    OP_JMP = 2'b11
  } br_op_e;

  typedef struct packed {
    br_op_e            op;
    logic              zero;
    logic [XLEN-1:0]   offset;
    logic [JTW-1:0]    target;
  } br_req_t;

  state_e          state_q, state_d;
  br_req_t         req_q, req_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] next_pc_q, next_pc_d;
  logic            taken_q, taken_d;
  logic            flush_q, flush_d;
  logic            in_ready_q, in_ready_d;
  logic            next_valid_q, next_valid_d;

  logic [XLEN-1:0] pc4_c;
  logic [XLEN-1:0] br_target_c;
  logic [XLEN-1:0] jmp_pc_c;
  logic            commit_c;

  // Target arithmetic; offset shift drops the top two bits and the sum wraps at 32 bits
  assign pc4_c       = pc_q + XLEN'(4);
  assign br_target_c = pc4_c + {req_q.offset[XLEN-3:0], 2'b00};
  assign jmp_pc_c    = {pc4_c[XLEN-1:XLEN-4], req_q.target, 2'b00};
  assign commit_c    = (state_q == ST_COMMIT) && bus.next_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      pc_q         <= PC_RESET;
      next_pc_q    <= '0;
      taken_q      <= 1'b0;
      flush_q      <= 1'b0;
      in_ready_q   <= 1'b1;
      next_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      pc_q         <= pc_d;
      next_pc_q    <= next_pc_d;
      taken_q      <= taken_d;
      flush_q      <= flush_d;
      in_ready_q   <= in_ready_d;
      next_valid_q <= next_valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    pc_d      = pc_q;
    next_pc_d = next_pc_q;
    taken_d   = taken_q;
    flush_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          req_d.op     = br_op_e'(bus.br_op);
          req_d.zero   = bus.alu_zero;
          req_d.offset = bus.br_offset;
          req_d.target = bus.jmp_target;
          state_d      = ST_EVAL;
        end
      end
      ST_EVAL: begin
        unique case (req_q.op)
          OP_SEQ: begin
            next_pc_d = pc4_c;
            taken_d   = 1'b0;
          end
          OP_BEQ: begin
            taken_d   = req_q.zero;
            next_pc_d = req_q.zero ? br_target_c : pc4_c;
          end
          OP_BNE: begin
            taken_d   = !req_q.zero;
            next_pc_d = req_q.zero ? pc4_c : br_target_c;
          end
          OP_JMP: begin
            taken_d   = 1'b1;
            next_pc_d = jmp_pc_c;
          end
          default: begin
            next_pc_d = pc4_c;
            taken_d   = 1'b0;
          end
        endcase
        state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (bus.next_ready) begin
          pc_d    = next_pc_q;
          flush_d = taken_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Handshake outputs registered from the upcoming state
    in_ready_d   = (state_d == ST_IDLE);
    next_valid_d = (state_d == ST_COMMIT);
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.pc         = pc_q;
  assign bus.next_pc    = next_pc_q;
  assign bus.next_valid = next_valid_q;
  assign bus.taken      = taken_q;
  assign bus.flush      = flush_q;

`ifdef BRANCH_STATS_EN
  logic [CNTW-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNTW-1:0] res_cnt_q, res_cnt_d;

  // Saturating commit counters
  always_comb begin
    taken_cnt_d = taken_cnt_q;
    res_cnt_d   = res_cnt_q;
    if (commit_c) begin
      if (res_cnt_q != {CNTW{1'b1}}) res_cnt_d = res_cnt_q + CNTW'(1);
      if (taken_q && (taken_cnt_q != {CNTW{1'b1}})) taken_cnt_d = taken_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_cnt_q <= '0;
      res_cnt_q   <= '0;
    end else begin
      taken_cnt_q <= taken_cnt_d;
      res_cnt_q   <= res_cnt_d;
    end
  end

  assign taken_count    = taken_cnt_q;
  assign resolved_count = res_cnt_q;
`else
  logic unused_commit_c;
  assign unused_commit_c = commit_c;
`endif

endmodule

// File: tb/tb_branch_resolve_stage.sv
// Directed bench for branch_resolve_stage: transaction-level PC model checked every cycle, plus literal PC pins.
module tb_branch_resolve_stage;
  logic clk;
  logic rst;
  branch_resolve_stage_if bus();

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_count;
  logic [15:0] resolved_count;
  int m_tak;
  int m_res;
`endif

  branch_resolve_stage #(.PC_RESET(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus)
`ifdef BRANCH_STATS_EN
    ,
    .taken_count    (taken_count),
    .resolved_count (resolved_count)
`endif
  );

  int errors;
  int checks;
  bit chk_en;

  // Model of what the outputs must be this cycle
  logic [31:0] m_pc;
  logic [31:0] m_next;
  logic        m_taken;
  logic        m_nv;
  logic        m_in_ready;
  logic        m_flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", bus.pc, m_pc);
      check("flush", 32'(bus.flush), 32'(m_flush));
      check("in_ready", 32'(bus.in_ready), 32'(m_in_ready));
      check("next_valid", 32'(bus.next_valid), 32'(m_nv));
      if (m_nv) begin
        check("next_pc", bus.next_pc, m_next);
        check("taken", 32'(bus.taken), 32'(m_taken));
      end
`ifdef BRANCH_STATS_EN
      check("resolved_count", 32'(resolved_count), 32'(m_res));
      check("taken_count", 32'(taken_count), 32'(m_tak));
`endif
    end
  end

  // Spec-level resolution of one instruction
  task automatic resolve(input logic [1:0] op, input logic z, input logic [31:0] off,
                         input logic [25:0] jt, output logic [31:0] nxt, output logic tk);
    logic [31:0] pc4;
    pc4 = m_pc + 32'd4;
    case (op)
      2'b00: begin nxt = pc4; tk = 1'b0; end
      2'b01: begin tk = z;  nxt = tk ? pc4 + off * 32'd4 : pc4; end
      2'b10: begin tk = !z; nxt = tk ? pc4 + off * 32'd4 : pc4; end
      default: begin tk = 1'b1; nxt = (pc4 & 32'hF000_0000) | ({6'd0, jt} * 32'd4); end
    endcase
  endtask

  task automatic model_reset();
    m_pc       = 32'h0;
    m_next     = 32'h0;
    m_taken    = 1'b0;
    m_nv       = 1'b0;
    m_in_ready = 1'b1;
    m_flush    = 1'b0;
`ifdef BRANCH_STATS_EN
    m_tak = 0;
    m_res = 0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full instruction; stall = cycles next_ready is held low in COMMIT
  task automatic txn(input logic [1:0] op, input logic z, input logic [31:0] off,
                     input logic [25:0] jt, input int stall, input logic [31:0] lit_pc);
    bus.in_valid   = 1'b1;
    bus.br_op      = op;
    bus.alu_zero   = z;
    bus.br_offset  = off;
    bus.jmp_target = jt;
    bus.next_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    resolve(op, z, off, jt, m_next, m_taken);
    m_in_ready = 1'b0;
    m_flush    = 1'b0;
    tick();
    m_nv = 1'b1;
    if (stall > 0) begin
      // Stray request with different fields while stalled must be ignored
      bus.in_valid   = 1'b1;
      bus.br_op      = 2'b11;
      bus.jmp_target = 26'h3FF_FFFF;
      bus.alu_zero   = ~z;
      repeat (stall) tick();
      bus.in_valid = 1'b0;
    end
    bus.next_ready = 1'b1;
    tick();
    bus.next_ready = 1'b0;
    m_pc       = m_next;
    m_flush    = m_taken;
    m_nv       = 1'b0;
    m_in_ready = 1'b1;
`ifdef BRANCH_STATS_EN
    m_res++;
    if (m_taken) m_tak++;
`endif
    check("pc_literal", bus.pc, lit_pc);
    tick();
    m_flush = 1'b0;
  endtask

  // Reset asserted in EVAL (in_commit=0) or in COMMIT (in_commit=1)
  task automatic mid_reset(input bit in_commit);
    bus.in_valid   = 1'b1;
    bus.br_op      = 2'b11;
    bus.jmp_target = 26'h000_0040;
    bus.next_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    resolve(2'b11, 1'b0, 32'h0, 26'h000_0040, m_next, m_taken);
    m_in_ready = 1'b0;
    m_flush    = 1'b0;
    if (in_commit) begin
      tick();
      m_nv = 1'b1;
      bus.next_ready = 1'b0;
    end
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_pc", bus.pc, 32'h0);
    check("rst_next_pc", bus.next_pc, 32'h0);
    check("rst_taken", 32'(bus.taken), 32'h0);
    check("rst_next_valid", 32'(bus.next_valid), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    rst = 1'b0;
    bus.next_ready = 1'b1;
    repeat (3) tick();
    bus.next_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    chk_en = 1'b0;
    rst = 1'b1;
    bus.in_valid   = 1'b0;
    bus.br_op      = 2'b00;
    bus.alu_zero   = 1'b0;
    bus.br_offset  = 32'h0;
    bus.jmp_target = 26'h0;
    bus.next_ready = 1'b0;
    model_reset();
    tick();
    tick();
    check("reset_pc", bus.pc, 32'h0);
    check("reset_next_pc", bus.next_pc, 32'h0);
    check("reset_taken", 32'(bus.taken), 32'h0);
    check("reset_flush", 32'(bus.flush), 32'h0);
    check("reset_in_ready", 32'(bus.in_ready), 32'h1);
    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    txn(2'b00, 1'b0, 32'h0,         26'h0,       0, 32'h0000_0004);  // SEQ
    txn(2'b11, 1'b0, 32'h0,         26'h000_0040, 0, 32'h0000_0100); // JMP to 0x100
    txn(2'b01, 1'b1, 32'hFFFF_FFFE, 26'h0,       0, 32'h0000_00FC);  // BEQ taken, backward
    txn(2'b11, 1'b0, 32'h0,         26'h000_0040, 0, 32'h0000_0100);
    txn(2'b01, 1'b0, 32'hFFFF_FFFE, 26'h0,       0, 32'h0000_0104);  // BEQ not taken
    txn(2'b11, 1'b0, 32'h0,         26'h000_0040, 0, 32'h0000_0100);
    txn(2'b10, 1'b0, 32'h0000_0003, 26'h0,       0, 32'h0000_0110);  // BNE taken
    txn(2'b10, 1'b1, 32'h0000_0003, 26'h0,       1, 32'h0000_0114);  // BNE not taken
    txn(2'b10, 1'b0, 32'hFFFF_FFB9, 26'h0,       0, 32'hFFFF_FFFC);  // reach top of space
    txn(2'b00, 1'b0, 32'h0,         26'h0,       0, 32'h0000_0000);  // SEQ wrap
    txn(2'b01, 1'b1, 32'h0BFF_FFFF, 26'h0,       0, 32'h3000_0000);
    txn(2'b11, 1'b0, 32'h0,         26'h000_0040, 5, 32'h3000_0100); // JMP with 5-cycle stall

    mid_reset(1'b0);
    mid_reset(1'b1);

    txn(2'b00, 1'b0, 32'h0,         26'h0,       0, 32'h0000_0004);
    txn(2'b11, 1'b0, 32'h0,         26'h000_0040, 2, 32'h0000_0100);
    txn(2'b01, 1'b1, 32'h0000_0010, 26'h0,       0, 32'h0000_0144);
`ifdef BRANCH_STATS_EN
    check("stats_resolved", 32'(resolved_count), 32'd3);
    check("stats_taken", 32'(taken_count), 32'd2);
`endif
    tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
